// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detect, pending store, round-robin event slot.
// Optional timestamps (ev_ts and a free-running counter) are built only when EDGE_ARB_TS_EN is defined.
// Ports:
//   clk, rst          clock, async active-high reset
//   din, mode         channel inputs, 2-bit edge mode per channel
//   ev_valid/ev_ready event handshake
//   ev_id, ev_pol     channel id and edge polarity (1 = rising) of the presented event
//   ev_ts             detection timestamp (EDGE_ARB_TS_EN only)
//   ovf, ovf_clr      sticky overflow flags, per-bit clear pulse
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int IDW  = 2,
  parameter int TSW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   din,
  input  logic [2*N_CH-1:0] mode,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [IDW-1:0]    ev_id,
  output logic              ev_pol,
`ifdef EDGE_ARB_TS_EN
  output logic [TSW-1:0]    ev_ts,
`endif
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  if (N_CH < 2 || N_CH > 16 || IDW != $clog2(N_CH) || TSW < 1) begin : g_param_err
    $error("edge_event_arbiter: bad parameters");
  end

  state_t          state_q;
  logic            init_q;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] pend_v;
  logic [N_CH-1:0] pend_pol;
  logic [IDW-1:0]  rr_q;

`ifdef EDGE_ARB_TS_EN
  logic [TSW-1:0]  ts_q;
  logic [TSW-1:0]  pend_ts [N_CH];
`endif

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] qual;
  logic [N_CH-1:0] take;
  logic [N_CH-1:0] ovf_set;
  logic            found;
  logic [IDW-1:0]  win;
  logic            load;

  assign ev_valid = (state_q == FULL);

  // The init cycle after reset only primes prev_q, so no edge qualifies.
  always_comb begin
    rise = din & ~prev_q;
    fall = ~din & prev_q;
    qual = '0;
    for (int i = 0; i < N_CH; i++) begin
      qual[i] = !init_q &&
                ((rise[i] && mode[2*i]) ||
                 (fall[i] && mode[2*i+1]));
    end
  end

  // Round-robin search begins one past the last winner.
  always_comb begin
    logic [IDW:0] s;
    found = 1'b0;
    win   = '0;
    s     = '0;
    for (int k = 1; k <= N_CH; k++) begin
      s = {1'b0, rr_q} + (IDW+1)'(k);
      if (s >= (IDW+1)'(N_CH)) begin
        s = s - (IDW+1)'(N_CH);
      end
      if (!found && pend_v[s[IDW-1:0]]) begin
        found = 1'b1;
        win   = s[IDW-1:0];
      end
    end
  end

  assign load = (!ev_valid || ev_ready) && found;

  always_comb begin
    take = '0;
    if (load) begin
      take[win] = 1'b1;
    end
  end

  // An entry leaving for the slot frees room for an edge in the same cycle.
  assign ovf_set = qual & pend_v & ~take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      init_q   <= 1'b1;
      prev_q   <= '0;
      pend_v   <= '0;
      pend_pol <= '0;
      rr_q     <= '0;
      ev_id    <= '0;
      ev_pol   <= 1'b0;
      ovf      <= '0;
`ifdef EDGE_ARB_TS_EN
      ts_q     <= '0;
      ev_ts    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        pend_ts[i] <= '0;
      end
`endif
    end else begin
      init_q <= 1'b0;
      prev_q <= din;
      ovf    <= (ovf & ~ovf_clr) | ovf_set;
`ifdef EDGE_ARB_TS_EN
      ts_q   <= ts_q + 1'b1;
`endif

      for (int i = 0; i < N_CH; i++) begin
        if (qual[i] && (!pend_v[i] || take[i])) begin
          pend_v[i]   <= 1'b1;
          pend_pol[i] <= rise[i];
`ifdef EDGE_ARB_TS_EN
          pend_ts[i]  <= ts_q;
`endif
        end else if (take[i]) begin
          pend_v[i] <= 1'b0;
        end
      end

      if (load) begin
        ev_id  <= win;
        ev_pol <= pend_pol[win];
        rr_q   <= win;
`ifdef EDGE_ARB_TS_EN
        ev_ts  <= pend_ts[win];
`endif
      end

      unique case (state_q)
        EMPTY: begin
          if (found) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          if (ev_ready && !found) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vector table plus hand sequences
// for edge_event_arbiter (default N_CH=4).
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [7:0] mode;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_id;
  logic       ev_pol;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;
`ifdef EDGE_ARB_TS_EN
  logic [15:0] ev_ts;
`endif

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0] din;
    logic [7:0] mode;
    logic       rdy;
    logic [3:0] clr;
    logic       v;
    logic [1:0] id;
    logic       pol;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  edge_event_arbiter #(
    .N_CH(4),
    .IDW (2),
    .TSW (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .mode    (mode),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_id   (ev_id),
    .ev_pol  (ev_pol),
`ifdef EDGE_ARB_TS_EN
    .ev_ts   (ev_ts),
`endif
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] d, input logic [7:0] m,
                     input logic r, input logic [3:0] c,
                     input logic v, input logic [1:0] id,
                     input logic p, input logic [3:0] o);
    vec_t e;
    e.din = d; e.mode = m; e.rdy = r; e.clr = c;
    e.v = v; e.id = id; e.pol = p; e.ovf = o;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; din = 4'h0; mode = 8'h55;
    ev_ready = 1'b1; ovf_clr = 4'h0;

    // din d, mode, ready, clr -> valid, id, pol, ovf after the edge
    // single rising event, one cycle only
    add(4'h0, 8'h55, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'h1, 8'h55, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'h1, 8'h55, 1, 4'h0, 1, 0, 1, 4'h0);
    add(4'h1, 8'h55, 1, 4'h0, 0, 0, 0, 4'h0);
    // falling on ch0, then four simultaneous rises
    add(4'h0, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'h0, 8'hFF, 1, 4'h0, 1, 0, 0, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 1, 1, 1, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 1, 2, 1, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 1, 3, 1, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 1, 0, 1, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    // bring ch0 low again
    add(4'hE, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hE, 8'hFF, 1, 4'h0, 1, 0, 0, 4'h0);
    add(4'hE, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    // three toggles with ready low -> held event, overflow, clear
    add(4'hF, 8'hFF, 0, 4'h0, 0, 0, 0, 4'h0);
    add(4'hE, 8'hFF, 0, 4'h0, 1, 0, 1, 4'h0);
    add(4'hF, 8'hFF, 0, 4'h0, 1, 0, 1, 4'h1);
    add(4'hF, 8'hFF, 0, 4'h0, 1, 0, 1, 4'h1);
    add(4'hF, 8'hFF, 0, 4'h1, 1, 0, 1, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 1, 0, 0, 4'h0);
    add(4'hF, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    // overflow set and clear in the same cycle: set wins
    add(4'hE, 8'hFF, 0, 4'h0, 0, 0, 0, 4'h0);
    add(4'hE, 8'hFF, 0, 4'h0, 1, 0, 0, 4'h0);
    add(4'hF, 8'hFF, 0, 4'h0, 1, 0, 0, 4'h0);
    add(4'hE, 8'hFF, 0, 4'h1, 1, 0, 0, 4'h1);
    add(4'hE, 8'hFF, 1, 4'h1, 1, 0, 1, 4'h0);
    add(4'hE, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    // ch1 edge in the cycle its entry moves to the slot
    add(4'hC, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hE, 8'hFF, 1, 4'h0, 1, 1, 0, 4'h0);
    add(4'hE, 8'hFF, 1, 4'h0, 1, 1, 1, 4'h0);
    add(4'hE, 8'hFF, 1, 4'h0, 0, 0, 0, 4'h0);
    // mode off, rising-only, mode change keeps pending entry
    add(4'h0, 8'h00, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hF, 8'h00, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hE, 8'h55, 0, 4'h0, 0, 0, 0, 4'h0);
    add(4'hF, 8'h55, 0, 4'h0, 0, 0, 0, 4'h0);
    add(4'hF, 8'h00, 0, 4'h0, 1, 0, 1, 4'h0);
    add(4'hF, 8'h00, 1, 4'h0, 0, 0, 0, 4'h0);
    // falling-only mode
    add(4'hF, 8'hAA, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hB, 8'hAA, 1, 4'h0, 0, 0, 0, 4'h0);
    add(4'hB, 8'hAA, 1, 4'h0, 1, 2, 0, 4'h0);
    add(4'hF, 8'hAA, 1, 4'h0, 0, 0, 0, 4'h0);

    // reset values
    #3;
    chk("rst_valid", ev_valid, 0);
    chk("rst_id", ev_id, 0);
    chk("rst_pol", ev_pol, 0);
    chk("rst_ovf", ovf, 0);

    // static-high inputs through reset release
    din = 4'hF; mode = 8'hFF; ev_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_quiet", ev_valid, 0);
    end
    din = 4'hB;
    step();
    chk("t2_pend", ev_valid, 0);
    step();
    chk("t2_valid", ev_valid, 1);
    chk("t2_id", ev_id, 2);
    chk("t2_pol", ev_pol, 0);
    step();
    chk("t2_done", ev_valid, 0);

    // reset while an event is held and another is pending
    ev_ready = 1'b0;
    din = 4'hF;
    step();
    step();
    chk("mr_valid", ev_valid, 1);
    chk("mr_pol", ev_pol, 1);
    din = 4'hB;
    step();
    chk("mr_hold_id", ev_id, 2);
    chk("mr_hold_pol", ev_pol, 1);
    din = 4'hF;
    step();
    chk("mr_ovf", ovf, 4'h4);
    rst = 1'b1;
    #1;
    chk("mr_async_valid", ev_valid, 0);
    chk("mr_async_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_discard", ev_valid, 0);
    end

    // vector table
    din = 4'h0; mode = 8'h55; ev_ready = 1'b1; ovf_clr = 4'h0;
    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      din = tbl[r].din;
      mode = tbl[r].mode;
      ev_ready = tbl[r].rdy;
      ovf_clr = tbl[r].clr;
      step();
      chk($sformatf("row%0d_valid", r), ev_valid, tbl[r].v);
      if (tbl[r].v) begin
        chk($sformatf("row%0d_id", r), ev_id, tbl[r].id);
        chk($sformatf("row%0d_pol", r), ev_pol, tbl[r].pol);
      end
      chk($sformatf("row%0d_ovf", r), ovf, tbl[r].ovf);
    end
    ovf_clr = 4'h0;

`ifdef EDGE_ARB_TS_EN
    // timestamp captured at 0xFFFE and held while ready is low
    din = 4'h0; mode = 8'hFF; ev_ready = 1'b0;
    do_reset();
    repeat (16'hFFFE) @(posedge clk);
    #1 din = 4'h8;
    step();
    step();
    chk("ts_valid", ev_valid, 1);
    chk("ts_id", ev_id, 3);
    chk("ts_val", ev_ts, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ts_hold_valid", ev_valid, 1);
      chk("ts_hold_val", ev_ts, 16'hFFFE);
    end
    rst = 1'b1;
    #1;
    chk("ts_rst_valid", ev_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
